// File: rtl/seg7_decoder.sv
// Segment-bus monitor: filters active-low 7-segment codes for stability,
// decodes settled codes to BCD, delivers digits over valid/ready, counts illegal codes.
module seg7_decoder #(
   parameter int STABLE_CNT = 3,
   parameter int DIGITS     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg_in,
   input  logic                  seg_valid,
   output logic                  seg_ready,
   output logic [3:0]            digit_out,
   output logic                  digit_valid,
   input  logic                  digit_ready,
   output logic                  invalid,
   output logic [7:0]            err_count,
   output logic [4*DIGITS-1:0]   history
);

   localparam int RW = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CNT);
   localparam int HW = 4 * DIGITS;

   logic [7:0]    last_code_q, last_code_d;
   logic [RW-1:0] run_q, run_d;
   logic [3:0]    digit_out_q, digit_out_d;
   logic          digit_valid_q, digit_valid_d;
   logic          invalid_q, invalid_d;
   logic [7:0]    err_q, err_d;
   logic [HW-1:0] history_q, history_d;

   logic          xfer;
   logic          same;
   logic          settle;
   logic          legal;
   logic          blank;
   logic [3:0]    dig;

   // Backpressure stalls the input so a pending digit is never overwritten.
   assign seg_ready = !rst && (!digit_valid_q || digit_ready);
   assign xfer      = seg_valid && seg_ready;
   assign same      = (seg_in == last_code_q);

   always_comb begin
      legal = 1'b1;
      blank = 1'b0;
      dig   = '0;
      case (seg_in)
         8'hC0:   dig = 4'd0;
         8'hF9:   dig = 4'd1;
         8'hA4:   dig = 4'd2;
         8'hB0:   dig = 4'd3;
         8'h99:   dig = 4'd4;
         8'h92:   dig = 4'd5;
         8'h82:   dig = 4'd6;
         8'hF8:   dig = 4'd7;
         8'h80:   dig = 4'd8;
         8'h90:   dig = 4'd9;
         8'hFF: begin
            legal = 1'b0;
            blank = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Settle fires only on the transfer that first brings the run to STABLE_CNT;
   // a code change with STABLE_CNT=1 settles at once.
   always_comb begin
      last_code_d = last_code_q;
      run_d       = run_q;
      settle      = 1'b0;
      if (xfer) begin
         if (same) begin
            if (run_q != RUN_MAX) begin
               run_d = run_q + RW'(1);
            end
            settle = (run_q == RUN_MAX - RW'(1));
         end else begin
            last_code_d = seg_in;
            run_d       = RW'(1);
            settle      = (STABLE_CNT == 1);
         end
      end
   end

   always_comb begin
      digit_valid_d = digit_valid_q && !digit_ready;
      digit_out_d   = digit_out_q;
      history_d     = history_q;
      invalid_d     = 1'b0;
      err_d         = err_q;
      if (settle) begin
         if (legal) begin
            digit_valid_d  = 1'b1;
            digit_out_d    = dig;
            history_d      = history_q << 4;
            history_d[3:0] = dig;
         end else if (!blank) begin
            invalid_d = 1'b1;
            if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_code_q   <= 8'hFF;
         run_q         <= '0;
         digit_out_q   <= '0;
         digit_valid_q <= 1'b0;
         invalid_q     <= 1'b0;
         err_q         <= '0;
         history_q     <= '0;
      end else begin
         last_code_q   <= last_code_d;
         run_q         <= run_d;
         digit_out_q   <= digit_out_d;
         digit_valid_q <= digit_valid_d;
         invalid_q     <= invalid_d;
         err_q         <= err_d;
         history_q     <= history_d;
      end
   end

   assign digit_out   = digit_out_q;
   assign digit_valid = digit_valid_q;
   assign invalid     = invalid_q;
   assign err_count   = err_q;
   assign history     = history_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder with STABLE_CNT=3, DIGITS=4.
module tb_seg7_decoder;

   logic        clk;
   logic        rst;
   logic [7:0]  seg_in;
   logic        seg_valid;
   logic        seg_ready;
   logic [3:0]  digit_out;
   logic        digit_valid;
   logic        digit_ready;
   logic        invalid;
   logic [7:0]  err_count;
   logic [15:0] history;

   int nchecks = 0;
   int nerrors = 0;

   seg7_decoder #(.STABLE_CNT(3), .DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .seg_valid   (seg_valid),
      .seg_ready   (seg_ready),
      .digit_out   (digit_out),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .invalid     (invalid),
      .err_count   (err_count),
      .history     (history)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] code);
      seg_in    = code;
      seg_valid = 1'b1;
      step();
   endtask

   task automatic idle();
      seg_valid = 1'b0;
      step();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      seg_valid   = 1'b0;
      seg_in      = 8'hFF;
      digit_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; seg_valid = 1'b0; seg_in = 8'hFF; digit_ready = 1'b1;
      step();
      chk("rst_seg_ready", seg_ready, 0);
      step();
      chk("rst_digit_valid", digit_valid, 0);
      chk("rst_digit_out", digit_out, 0);
      chk("rst_invalid", invalid, 0);
      chk("rst_err", err_count, 0);
      chk("rst_history", history, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_seg_ready", seg_ready, 1);

      // Basic settle of A4 -> 2
      send(8'hA4);
      send(8'hA4);
      chk("t1_no_early", digit_valid, 0);
      send(8'hA4);
      chk("t1_valid", digit_valid, 1);
      chk("t1_digit", digit_out, 2);
      chk("t1_hist", history, 16'h0002);
      idle();
      chk("t1_one_cycle", digit_valid, 0);

      // 92 x5: single emission of 5
      do_reset();
      send(8'h92);
      send(8'h92);
      chk("t2_s2", digit_valid, 0);
      send(8'h92);
      chk("t2_valid", digit_valid, 1);
      chk("t2_digit", digit_out, 5);
      send(8'h92);
      chk("t2_s4", digit_valid, 0);
      send(8'h92);
      chk("t2_s5", digit_valid, 0);
      chk("t2_hist", history, 16'h0005);

      // Glitch rejection
      do_reset();
      send(8'h99); chk("t3_s1", digit_valid, 0);
      send(8'h99); chk("t3_s2", digit_valid, 0);
      send(8'hB0); chk("t3_s3", digit_valid, 0);
      send(8'h99); chk("t3_s4", digit_valid, 0);
      send(8'h99); chk("t3_s5", digit_valid, 0);
      send(8'h99);
      chk("t3_valid", digit_valid, 1);
      chk("t3_digit", digit_out, 4);
      chk("t3_hist", history, 16'h0004);
      idle();

      // Gaps in seg_valid do not break a run
      do_reset();
      send(8'hF9); idle(); send(8'hF9); idle(); idle();
      chk("gap_pending", digit_valid, 0);
      send(8'hF9);
      chk("gap_valid", digit_valid, 1);
      chk("gap_digit", digit_out, 1);
      idle();

      // Backpressure
      do_reset();
      digit_ready = 1'b0;
      send(8'hF8); send(8'hF8); send(8'hF8);
      chk("bp_valid", digit_valid, 1);
      chk("bp_digit", digit_out, 7);
      chk("bp_seg_ready", seg_ready, 0);
      for (int i = 0; i < 4; i++) begin
         send(8'h80);
         chk("bp_hold_digit", digit_out, 7);
         chk("bp_hold_valid", digit_valid, 1);
         chk("bp_hold_ready", seg_ready, 0);
      end
      digit_ready = 1'b1;
      #1;
      chk("bp_release_ready", seg_ready, 1);
      send(8'h80); chk("bp_x1", digit_valid, 0);
      send(8'h80); chk("bp_x2", digit_valid, 0);
      send(8'h80);
      chk("bp_valid8", digit_valid, 1);
      chk("bp_digit8", digit_out, 8);
      chk("bp_hist", history, 16'h0078);
      idle();

      // Illegal, DP-lit and blank codes
      do_reset();
      send(8'h55); send(8'h55);
      chk("ill_no_early", invalid, 0);
      send(8'h55);
      chk("ill_pulse", invalid, 1);
      chk("ill_err1", err_count, 1);
      chk("ill_no_digit", digit_valid, 0);
      send(8'h55);
      chk("ill_pulse_end", invalid, 0);
      chk("ill_err_hold", err_count, 1);
      send(8'h40); send(8'h40); send(8'h40);
      chk("dp_pulse", invalid, 1);
      chk("dp_err2", err_count, 2);
      chk("dp_no_digit", digit_valid, 0);
      for (int i = 0; i < 3; i++) begin
         send(8'hFF);
         chk("blank_no_pulse", invalid, 0);
         chk("blank_no_digit", digit_valid, 0);
      end
      chk("blank_err", err_count, 2);

      // Saturation: 300 more illegal settles
      for (int i = 0; i < 300; i++) begin
         send((i % 2 == 0) ? 8'h56 : 8'h57);
         send((i % 2 == 0) ? 8'h56 : 8'h57);
         send((i % 2 == 0) ? 8'h56 : 8'h57);
         if (i == 97) chk("sat_mid", err_count, 100);
      end
      chk("sat_pulse", invalid, 1);
      chk("sat_err", err_count, 255);
      chk("sat_hist", history, 16'h0000);
      idle();

      // Reset mid-run
      do_reset();
      send(8'hC0); send(8'hC0);
      rst = 1'b1; seg_valid = 1'b0;
      #1;
      chk("mid_rst_ready", seg_ready, 0);
      step();
      rst = 1'b0;
      send(8'hC0);
      chk("mid_no_emit", digit_valid, 0);
      send(8'hC0);
      chk("mid_no_emit2", digit_valid, 0);
      send(8'hC0);
      chk("mid_valid", digit_valid, 1);
      chk("mid_digit", digit_out, 0);
      chk("mid_hist", history, 16'h0000);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
